// File: rtl/mc_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_unit_if
// Brief    : Fetch/memory handshake and control-strobe bundle of the
//            multi-cycle control unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mc_control_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic [31:0]          instr;
    logic                 imem_ready;
    logic                 dmem_ready;
    logic                 zero;
    logic [31:0]          ir;
    logic                 pcload;
    logic                 pcSource;
    logic                 registerWrite;
    logic                 dataMemToReg;
    logic                 MemRead;
    logic                 MemWrite;
    logic [3:0]           ALUControl;
    logic                 ALUSource;
    logic [2:0]           state;
    logic                 trap;
    logic [1:0]           trap_cause;
    logic [CNT_WIDTH-1:0] retired_cnt;
    logic [CNT_WIDTH-1:0] stall_cnt;

    modport master (
        output instr, imem_ready, dmem_ready, zero,
        input  ir, pcload, pcSource, registerWrite, dataMemToReg, MemRead,
               MemWrite, ALUControl, ALUSource, state, trap, trap_cause,
               retired_cnt, stall_cnt
    );

    modport slave (
        input  instr, imem_ready, dmem_ready, zero,
        output ir, pcload, pcSource, registerWrite, dataMemToReg, MemRead,
               MemWrite, ALUControl, ALUSource, state, trap, trap_cause,
               retired_cnt, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_unit
// Brief    : Multi-cycle RV32I-subset control FSM with illegal-instruction
//            and memory-timeout trapping plus retire/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_unit #(
    parameter int CNT_WIDTH     = 32,
    parameter int MEM_TIMEOUT   = 15,
    parameter int CHECK_ILLEGAL = 1
) (
    input  logic             clk,
    input  logic             rst,
    mc_control_unit_if.slave bus
);
    localparam logic [2:0] S_IF   = 3'b000;
    localparam logic [2:0] S_ID   = 3'b001;
    localparam logic [2:0] S_EX   = 3'b010;
    localparam logic [2:0] S_MEM  = 3'b011;
    localparam logic [2:0] S_WB   = 3'b100;
    localparam logic [2:0] S_TRAP = 3'b101;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]           state_q, state_d;
    logic [31:0]          ir_q, ir_d;
    logic [1:0]           cause_q, cause_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic [31:0]          wait_q, wait_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       f7_ok, is_r, is_i, is_lw, is_sw, is_beq, is_bne, legal;
    logic [3:0] alu_op;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    // The alternate funct7 (0100000) only selects SUB and SRA.
    assign f7_ok  = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    assign is_r   = (opcode == 7'b0110011) && f7_ok;
    assign is_i   = (opcode == 7'b0010011) &&
                    (((funct3 == 3'b001) || (funct3 == 3'b101)) ? f7_ok : 1'b1);
    assign is_lw  = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_sw  = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign is_beq = (opcode == 7'b1100011) && (funct3 == 3'b000);
    assign is_bne = (opcode == 7'b1100011) && (funct3 == 3'b001);
    assign legal  = is_r | is_i | is_lw | is_sw | is_beq | is_bne;

    always_comb begin
        alu_op = ALU_ADD;
        if (is_beq || is_bne) begin
            alu_op = ALU_SUB;
        end else if (is_r || is_i) begin
            case (funct3)
                3'b000:  alu_op = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLT;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cause_d   = cause_q;
        retired_d = retired_q;
        stall_d   = stall_q;
        wait_d    = 32'd0;
        case (state_q)
            S_IF: begin
                if (bus.imem_ready) begin
                    ir_d    = bus.instr;
                    state_d = S_ID;
                end else begin
                    stall_d = stall_q + CNT_ONE;
                end
            end
            S_ID: begin
                if ((CHECK_ILLEGAL != 0) && !legal) begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: state_d = S_MEM;
            S_MEM: begin
                if ((is_lw || is_sw) && !bus.dmem_ready) begin
                    stall_d = stall_q + CNT_ONE;
                    wait_d  = wait_q + 32'd1;
                    if ((MEM_TIMEOUT > 0) && (wait_d == 32'(MEM_TIMEOUT))) begin
                        state_d = S_TRAP;
                        cause_d = 2'b10;
                    end
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                retired_d = retired_q + CNT_ONE;
                state_d   = S_IF;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            ir_q      <= 32'd0;
            cause_q   <= 2'b00;
            retired_q <= '0;
            stall_q   <= '0;
            wait_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
            stall_q   <= stall_d;
            wait_q    <= wait_d;
        end
    end

    // Strobes depend only on registered state, so reset clears them at once.
    assign bus.ir            = ir_q;
    assign bus.state         = state_q;
    assign bus.trap          = (state_q == S_TRAP);
    assign bus.trap_cause    = cause_q;
    assign bus.retired_cnt   = retired_q;
    assign bus.stall_cnt     = stall_q;
    assign bus.MemRead       = (state_q == S_MEM) && is_lw;
    assign bus.MemWrite      = (state_q == S_MEM) && is_sw;
    assign bus.pcload        = (state_q == S_WB);
    assign bus.registerWrite = (state_q == S_WB) && (is_r || is_i || is_lw);
    assign bus.dataMemToReg  = (state_q == S_WB) && is_lw;
    assign bus.pcSource      = (state_q == S_WB) &&
                               ((is_beq && bus.zero) || (is_bne && !bus.zero));
    assign bus.ALUControl    = alu_op;
    assign bus.ALUSource     = is_i | is_lw | is_sw;
endmodule
`default_nettype wire

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CNT_WIDTH, 32, width of the performance counters; MEM_TIMEOUT, 15, maximum dmem wait cycles in MEM before a trap (0 = no timeout); CHECK_ILLEGAL, 1, enables illegal-instruction trapping.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be (name direction width meaning):
clk  in  1  clock
rst  in  1  asynchronous active-high reset
instr  in  32  instruction memory read data
imem_ready  in  1  instr valid this cycle
dmem_ready  in  1  data memory access complete
zero  in  1  ALU zero flag
ir  out  32  latched instruction register
pcload  out  1  PC write enable
pcSource  out  1  1 = branch target, 0 = PC+4
registerWrite  out  1  register file write enable
dataMemToReg  out  1  1 = writeback from memory
MemRead  out  1  data memory read strobe
MemWrite  out  1  data memory write strobe
ALUControl  out  4  ALU operation code
ALUSource  out  1  1 = immediate operand
state  out  3  current FSM state
trap  out  1  sticky fault flag
trap_cause  out  2  01 illegal, 10 memory timeout, 00 none
retired_cnt  out  CNT_WIDTH  instructions retired
stall_cnt  out  CNT_WIDTH  cycles spent waiting on imem/dmem

Function
REQ-004 State encoding SHALL be IF=000, ID=001, EX=010, MEM=011, WB=100, TRAP=101; all other codes SHALL go to IF.
REQ-005 IF: when imem_ready=1, the FSM SHALL latch instr into ir and go to ID; otherwise it SHALL stay in IF and increment stall_cnt.
REQ-006 ID -> EX SHALL take one cycle, except that an illegal ir with CHECK_ILLEGAL=1 SHALL go to TRAP with trap_cause=01.
REQ-007 Legal opcodes SHALL be 0110011 (R), 0010011 (I-ALU), 0000011 (lw, funct3=010), 0100011 (sw, funct3=010) and 1100011 (beq funct3=000, bne funct3=001).
REQ-008 For R-type, funct7 SHALL be 0000000, or 0100000 only with funct3 000 or 101.
REQ-009 For I-type shifts (funct3 001/101), imm[11:5] SHALL follow the same funct7 rule.
REQ-010 All decode other than REQ-007..REQ-009 SHALL be illegal.
REQ-011 EX -> MEM SHALL take one cycle.
REQ-012 MEM, lw/sw: MemRead (lw) or MemWrite (sw) SHALL be held at 1 until dmem_ready=1, then the FSM SHALL go to WB; each wait cycle SHALL increment stall_cnt.
REQ-013 If MEM_TIMEOUT>0 and dmem_ready stays 0 for MEM_TIMEOUT consecutive MEM cycles, the FSM SHALL go to TRAP with cause 10.
REQ-014 MEM, non-memory instructions: the FSM SHALL go to WB in one cycle with both strobes at 0.
REQ-015 WB SHALL last exactly one cycle and SHALL then go to IF.
REQ-016 WB: pcload SHALL be 1 for one cycle.
REQ-017 WB: registerWrite SHALL be 1 for R, I-ALU and lw, and 0 for sw and branches.
REQ-018 WB: dataMemToReg SHALL be 1 only for lw.
REQ-019 WB: pcSource SHALL be (beq & zero) | (bne & ~zero).
REQ-020 WB: retired_cnt SHALL increment by 1.
REQ-021 pcload, registerWrite, pcSource, dataMemToReg, MemRead and MemWrite SHALL be 0 outside the states named above.
REQ-022 ALUControl SHALL be decoded combinationally from ir: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
REQ-023 ALUControl mapping by instruction: lw/sw = ADD; beq/bne = SUB; addi = ADD; slti = SLT; xori = XOR; ori = OR; andi = AND; slli/srli/srai = SLL/SRL/SRA; R-type by funct3/funct7 per RV32I.
REQ-024 ALUControl for illegal encodings SHALL be 0010.
REQ-025 ALUSource SHALL be 1 for I-ALU, lw and sw, and 0 otherwise.
REQ-026 TRAP SHALL be absorbing until reset: trap=1, trap_cause held, all strobes 0, counters frozen.
REQ-027 Counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-028 Only ir decode and FSM state SHALL drive the outputs; the live instr SHALL be ignored outside IF.

Reset
REQ-029 rst=1 SHALL immediately force: state=IF, ir=0, trap=0, trap_cause=00, both counters 0, every strobe 0, MemRead/MemWrite 0 even mid-MEM.
REQ-030 On rst deassertion, the next rising edge with imem_ready=1 SHALL latch ir.

Verification
REQ-031 add x3,x1,x2 (0x002081B3), imem_ready=1 -> IF,ID,EX,MEM,WB in 5 cycles; registerWrite=1 and ALUControl=0010 in WB; retired_cnt=1.
REQ-032 lw (0x0000A183) with dmem_ready low for 3 cycles -> MemRead high for 4 cycles; dataMemToReg=1 in WB; stall_cnt=3.
REQ-033 beq with zero=1 -> pcSource=1 in WB; bne with zero=1 -> pcSource=0.
REQ-034 Opcode 0x7F -> TRAP after ID; trap=1, cause=01; counters frozen across 10 further cycles.
REQ-035 sw with dmem_ready held 0, MEM_TIMEOUT=15 -> TRAP after 15 MEM cycles, cause=10; rst pulse mid-MEM -> state=000 and MemWrite=0 asynchronously.
